// File: rtl/uart_tx_top.sv
// UART frame transmitter: start / 8 data (LSB first) / optional parity / one stop bit.
// Optional macro UART_TX_BUF_EN adds a one-entry holding buffer for sends issued while busy.
module uart_tx_top #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       dout,
    output logic       busy,
    output logic       done_flag
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Rounded bit periods: (f + baud/2) / baud.
    localparam int DIV_2400  = (CLK_FREQ + 1200) / 2400;
    localparam int DIV_4800  = (CLK_FREQ + 2400) / 4800;
    localparam int DIV_9600  = (CLK_FREQ + 4800) / 9600;
    localparam int DIV_19200 = (CLK_FREQ + 9600) / 19200;

    function automatic logic [14:0] bit_period(input logic [1:0] code);
        case (code)
            2'b00:   return 15'(DIV_2400);
            2'b01:   return 15'(DIV_4800);
            2'b10:   return 15'(DIV_9600);
            default: return 15'(DIV_19200);
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  baud_q, baud_d;
    logic [1:0]  par_q, par_d;
    logic        dout_q, dout_d;
    logic        done_q, done_d;
    logic        period_end;
    logic        has_parity;

`ifdef UART_TX_BUF_EN
    logic        buf_valid_q, buf_valid_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic [1:0]  buf_baud_q, buf_baud_d;
    logic [1:0]  buf_par_q, buf_par_d;
`endif

    assign period_end = (cnt_q == (bit_period(baud_q) - 15'd1));
    assign has_parity = (par_q == 2'b01) || (par_q == 2'b10);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        baud_d    = baud_q;
        par_d     = par_q;
        done_d    = 1'b0;
`ifdef UART_TX_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_baud_d  = buf_baud_q;
        buf_par_d   = buf_par_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = 15'd0;
                bit_idx_d = 3'd0;
`ifdef UART_TX_BUF_EN
                // A pending buffered frame wins over a fresh send, which is dropped.
                if (buf_valid_q) begin
                    data_d      = buf_data_q;
                    baud_d      = buf_baud_q;
                    par_d       = buf_par_q;
                    buf_valid_d = 1'b0;
                    state_d     = START;
                end else if (send) begin
`else
                if (send) begin
`endif
                    data_d  = data_in;
                    baud_d  = baud_rate;
                    par_d   = parity_type;
                    state_d = START;
                end
            end
            START: begin
                if (period_end) begin
                    cnt_d   = 15'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_d = 15'd0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = has_parity ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            PARITY: begin
                if (period_end) begin
                    cnt_d   = 15'd0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            STOP: begin
                if (period_end) begin
                    cnt_d   = 15'd0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = 15'd0;
                bit_idx_d = 3'd0;
            end
        endcase

`ifdef UART_TX_BUF_EN
        if (send && (state_q != IDLE) && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_in;
            buf_baud_d  = baud_rate;
            buf_par_d   = parity_type;
        end
`endif

        // Line level is registered from the next state so dout is glitch-free.
        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = data_d[bit_idx_d];
            PARITY:  dout_d = (par_d == 2'b01) ? ~(^data_d) : (^data_d);
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 15'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'd0;
            baud_q    <= 2'd0;
            par_q     <= 2'd0;
            dout_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            baud_q    <= baud_d;
            par_q     <= par_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_BUF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= 8'd0;
            buf_baud_q  <= 2'd0;
            buf_par_q   <= 2'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_baud_q  <= buf_baud_d;
            buf_par_q   <= buf_par_d;
        end
    end

    assign busy = (state_q != IDLE) || buf_valid_q;
`else
    assign busy = (state_q != IDLE);
`endif

    assign dout      = dout_q;
    assign done_flag = done_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: stimulus queues expected frames, a line monitor decodes dout.
// Runs the DUT at CLK_FREQ=5 MHz so bit periods are 2083/1042/521/260 cycles.
module tb_uart_tx_top;

    logic       clk;
    logic       reset;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] data_in;
    logic       send;
    logic       dout;
    logic       busy;
    logic       done_flag;

    localparam int D00 = 2083;
    localparam int D01 = 1042;
    localparam int D10 = 521;
    localparam int D11 = 260;

`ifdef UART_TX_BUF_EN
    localparam logic BUF_BUILD = 1'b1;
`else
    localparam logic BUF_BUILD = 1'b0;
`endif

    typedef struct {
        logic [10:0] bits;
        int          nbits;
        int          div;
        int          cut;
        bit          chained;
        logic        busy_done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    int   frames_expected = 0;
    int   cyc = 0;
    int   last_done_cyc = -10;

    uart_tx_top #(.CLK_FREQ(5000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_rate  (baud_rate),
        .parity_type(parity_type),
        .data_in    (data_in),
        .send       (send),
        .dout       (dout),
        .busy       (busy),
        .done_flag  (done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Builds the expected frame from the byte and a hand-computed parity bit.
    task automatic expectFrame(input logic [7:0] d, input logic par_bit, input int nbits,
                               input int div, input int cut, input bit chained,
                               input logic busy_done);
        exp_t e;
        e.bits      = 11'h7FF;
        e.bits[0]   = 1'b0;
        e.bits[8:1] = d;
        if (nbits == 11) e.bits[9] = par_bit;
        e.nbits     = nbits;
        e.div       = div;
        e.cut       = cut;
        e.chained   = chained;
        e.busy_done = busy_done;
        exp_q.push_back(e);
        frames_expected++;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pt);
        @(posedge clk); #1;
        data_in     = d;
        baud_rate   = br;
        parity_type = pt;
        send        = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic waitFrames(input int budget);
        int k = 0;
        while (frames_seen < frames_expected && k < budget) begin
            @(posedge clk);
            k++;
        end
        checkOutput("frame_wait_timeout", frames_seen, frames_expected);
        repeat (20) @(posedge clk);
    endtask

    // Line monitor: detects start bits, checks every cycle of the frame against the queue head.
    initial begin : monitor
        exp_t e;
        int   limit;
        int   first_bad;
        logic bad_busy;
        logic early_done;
        forever begin
            @(negedge clk);
            if (done_flag === 1'b1) checkOutput("unexpected_done", 1, 0);
            if (dout === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 1, 0);
                    while (dout !== 1'b1) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chained) checkOutput("back_to_back_gap", cyc, last_done_cyc + 1);
                    limit      = (e.cut > 0) ? e.cut : e.nbits * e.div;
                    first_bad  = -1;
                    bad_busy   = 1'b0;
                    early_done = 1'b0;
                    for (int c = 0; c < limit; c++) begin
                        if (c > 0) @(negedge clk);
                        if (dout !== e.bits[c / e.div] && first_bad < 0) first_bad = c;
                        if (busy !== 1'b1) bad_busy = 1'b1;
                        if (done_flag !== 1'b0) early_done = 1'b1;
                    end
                    if (first_bad >= 0)
                        $display("[TB] frame bits 0x%0h: first wrong dout at cycle %0d", e.bits, first_bad);
                    checkOutput("frame_dout", (first_bad < 0) ? 0 : 1, 0);
                    checkOutput("busy_in_frame", bad_busy, 0);
                    checkOutput("done_early", early_done, 0);
                    @(negedge clk);
                    if (e.cut > 0) begin
                        checkOutput("abort_dout", dout, 1);
                        checkOutput("abort_busy", busy, 0);
                        checkOutput("abort_done", done_flag, 0);
                    end else begin
                        checkOutput("done_timing", done_flag, 1);
                        checkOutput("stop_level_at_done", dout, 1);
                        checkOutput("busy_at_done", busy, e.busy_done);
                        last_done_cyc = cyc;
                    end
                    frames_seen++;
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        reset       = 1'b1;
        send        = 1'b0;
        data_in     = 8'h00;
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_dout", dout, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done_flag, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_dout", dout, 1);
        checkOutput("idle_busy", busy, 0);

        // 0x07, 19200, even: 0,1,1,1,0,0,0,0,0, parity 1, stop
        expectFrame(8'h07, 1'b1, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'h07, 2'b11, 2'b10);
        waitFrames(4000);
        // odd parity -> 0
        expectFrame(8'h07, 1'b0, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'h07, 2'b11, 2'b01);
        waitFrames(4000);
        // no parity -> 10-bit frame
        expectFrame(8'h07, 1'b0, 10, D11, 0, 0, 1'b0);
        applyStimulus(8'h07, 2'b11, 2'b00);
        waitFrames(4000);
        // parity code 11 also means none; 9600 baud
        expectFrame(8'h80, 1'b0, 10, D10, 0, 0, 1'b0);
        applyStimulus(8'h80, 2'b10, 2'b11);
        waitFrames(7000);

        // 0xA5 at 2400, inputs changed mid-frame must not matter
        expectFrame(8'hA5, 1'b0, 10, D00, 0, 0, 1'b0);
        applyStimulus(8'hA5, 2'b00, 2'b00);
        repeat (3000) @(posedge clk); #1;
        baud_rate   = 2'b11;
        parity_type = 2'b10;
        data_in     = 8'h00;
        waitFrames(22000);

        // 4800 baud
        expectFrame(8'hF0, 1'b0, 10, D01, 0, 0, 1'b0);
        applyStimulus(8'hF0, 2'b01, 2'b00);
        waitFrames(12000);

        // Reset in the middle of data bit 4, then a clean 0x3C frame
        expectFrame(8'hC3, 1'b0, 11, D11, 5 * D11 + D11 / 2, 0, 1'b0);
        applyStimulus(8'hC3, 2'b11, 2'b10);
        repeat (5 * D11 + D11 / 2) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_dout", dout, 1);
        checkOutput("async_reset_busy", busy, 0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        waitFrames(100);
        expectFrame(8'h3C, 1'b0, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'h3C, 2'b11, 2'b10);
        waitFrames(4000);

        // send held high: second frame starts straight out of the done cycle
        expectFrame(8'h5A, 1'b0, 10, D11, 0, 0, BUF_BUILD);
        expectFrame(8'hB4, 1'b0, 10, D11, 0, 1, 1'b0);
        @(posedge clk); #1;
        data_in     = 8'h5A;
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        send        = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hB4;
        k = 0;
        @(negedge clk);
        while (done_flag !== 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("held_send_done_seen", done_flag, 1);
        @(posedge clk); #1;
        send = 1'b0;
        waitFrames(4000);

        // Two sends 1000 cycles apart: the second only survives with the buffer
        expectFrame(8'h11, 1'b0, 10, D11, 0, 0, BUF_BUILD);
        if (BUF_BUILD) expectFrame(8'h22, 1'b0, 10, D11, 0, 1, 1'b0);
        applyStimulus(8'h11, 2'b11, 2'b00);
        repeat (1000) @(posedge clk);
        applyStimulus(8'h22, 2'b11, 2'b00);
        waitFrames(7000);
        @(negedge clk);
        checkOutput("idle_after_pair_busy", busy, 0);
        checkOutput("idle_after_pair_dout", dout, 1);

        // Loopback bytes at 19200 even parity (all parity bits 0)
        expectFrame(8'h00, 1'b0, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'h00, 2'b11, 2'b10);
        waitFrames(4000);
        expectFrame(8'hFF, 1'b0, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'hFF, 2'b11, 2'b10);
        waitFrames(4000);
        expectFrame(8'h55, 1'b0, 11, D11, 0, 0, 1'b0);
        applyStimulus(8'h55, 2'b11, 2'b10);
        waitFrames(4000);

        repeat (50) @(posedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
